// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inta_sequencer
// Description : Interrupt-acknowledge sequencer for an 8259-style controller.
//               Raises INT on a pending request, tracks the two INTA pulses,
//               freezes the winning level and configuration, drives the
//               cascade bus (master), selects on the cascade bus (slave),
//               presents the vector byte and pulses the in-service register.
//               Optional macro INTA_TIMEOUT_EN adds an 8-bit GAP watchdog
//               that aborts after 255 GAP cycles without a second INTA.
// Revision    : 1.0 - initial release
// ============================================================================
module inta_sequencer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       INTA_N,
  input  logic       PEND,
  input  logic [7:0] IRQ_HI,
  input  logic       SNGL,
  input  logic       SP_EN,
  input  logic       AEOI,
  input  logic [7:0] ICW3,
  input  logic [7:0] ICW2,
  input  logic [2:0] CAS_IN,
  output logic [2:0] CAS_OUT,
  output logic       CAS_OE,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       INT,
  output logic       BUSY,
  output logic [7:0] ISR_SET,
  output logic [7:0] EOI_CLR
);

  // Sequence states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACK1 = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_ACK2 = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

`ifdef INTA_TIMEOUT_EN
  // Last GAP cycle count value before the abort fires (255th GAP cycle)
  localparam logic [7:0] C_GAP_LAST = 8'd254;
`endif

  logic [2:0] state_q, state_d;
  logic       inta_prev_q;
  logic [2:0] lvl_q, lvl_d;
  logic       spur_q, spur_d;
  logic       sngl_q, sngl_d;
  logic       sp_q, sp_d;
  logic [7:0] icw3_q, icw3_d;
  logic [7:0] icw2_q, icw2_d;
  logic       sel_q, sel_d;
  logic       isr_fired_q, isr_fired_d;
  logic [7:0] isr_set_q, isr_set_d;
  logic [7:0] eoi_clr_q, eoi_clr_d;
`ifdef INTA_TIMEOUT_EN
  logic [7:0] gap_cnt_q, gap_cnt_d;
`endif

  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] irq_lvl;
  logic       irq_none;
  logic [7:0] lvl_onehot;
  logic [7:0] irq_onehot;
  logic       is_master;
  logic       is_slave;
  logic       cas_route;
  logic       resp;
  logic       in_ack;
  logic       slave_hit;

  // INTA edge detection against the previous-cycle strobe value
  assign inta_fall = inta_prev_q & ~INTA_N;
  assign inta_rise = ~inta_prev_q & INTA_N;

  // Lowest set bit of IRQ_HI wins; an empty request encodes as level 7
  always_comb begin
    irq_lvl = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (IRQ_HI[i]) irq_lvl = 3'(i);
    end
  end

  assign irq_none   = (IRQ_HI == 8'h00);
  assign irq_onehot = 8'b1 << irq_lvl;
  assign lvl_onehot = 8'b1 << lvl_q;

  // Role decode from the frozen configuration
  assign is_master = ~sngl_q & sp_q;
  assign is_slave  = ~sngl_q & ~sp_q;
  assign cas_route = is_master & icw3_q[lvl_q];
  assign resp      = sngl_q | (is_master & ~icw3_q[lvl_q]) | (is_slave & sel_q);
  assign in_ack    = (state_q == S_ACK1) | (state_q == S_GAP) | (state_q == S_ACK2);

  // Slave selection uses the frozen slave ID, sampled at the second fall
  assign slave_hit = is_slave & (CAS_IN == icw3_q[2:0]);

  // Next-state, freeze capture and in-service pulse generation
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    spur_d      = spur_q;
    sngl_d      = sngl_q;
    sp_d        = sp_q;
    icw3_d      = icw3_q;
    icw2_d      = icw2_q;
    sel_d       = sel_q;
    isr_fired_d = isr_fired_q;
    isr_set_d   = 8'h00;
    eoi_clr_d   = 8'h00;
`ifdef INTA_TIMEOUT_EN
    gap_cnt_d   = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // INTA activity is deliberately ignored here
        if (PEND) state_d = S_REQ;
      end
      S_REQ: begin
        // The acknowledge fall wins over a request that just went away
        if (inta_fall) begin
          state_d     = S_ACK1;
          lvl_d       = irq_lvl;
          spur_d      = irq_none;
          sngl_d      = SNGL;
          sp_d        = SP_EN;
          icw3_d      = ICW3;
          icw2_d      = ICW2;
          sel_d       = 1'b0;
          isr_fired_d = 1'b0;
          // Master and single mode mark in-service on the first pulse
          if ((SNGL | SP_EN) & ~irq_none) begin
            isr_set_d   = irq_onehot;
            isr_fired_d = 1'b1;
          end
        end else if (!PEND) begin
          state_d = S_IDLE;
        end
      end
      S_ACK1: begin
        if (inta_rise) begin
          state_d = S_GAP;
`ifdef INTA_TIMEOUT_EN
          gap_cnt_d = 8'd0;
`endif
        end
      end
      S_GAP: begin
        if (inta_fall) begin
          state_d = S_ACK2;
          sel_d   = slave_hit;
          // A selected slave marks in-service on the second pulse
          if (slave_hit & ~spur_q) begin
            isr_set_d   = lvl_onehot;
            isr_fired_d = 1'b1;
          end
`ifdef INTA_TIMEOUT_EN
        end else if (gap_cnt_q == C_GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
`endif
        end
      end
      S_ACK2: begin
        if (inta_rise) begin
          state_d = S_DONE;
          // Automatic EOI clears only what this sequence actually set
          if (AEOI & isr_fired_q) eoi_clr_d = lvl_onehot;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and frozen-context registers; reset returns everything to idle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      inta_prev_q <= 1'b1;
      lvl_q       <= 3'd0;
      spur_q      <= 1'b0;
      sngl_q      <= 1'b0;
      sp_q        <= 1'b0;
      icw3_q      <= 8'h00;
      icw2_q      <= 8'h00;
      sel_q       <= 1'b0;
      isr_fired_q <= 1'b0;
      isr_set_q   <= 8'h00;
      eoi_clr_q   <= 8'h00;
`ifdef INTA_TIMEOUT_EN
      gap_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      inta_prev_q <= INTA_N;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      sngl_q      <= sngl_d;
      sp_q        <= sp_d;
      icw3_q      <= icw3_d;
      icw2_q      <= icw2_d;
      sel_q       <= sel_d;
      isr_fired_q <= isr_fired_d;
      isr_set_q   <= isr_set_d;
      eoi_clr_q   <= eoi_clr_d;
`ifdef INTA_TIMEOUT_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  // Outputs are gated by state so IDLE (and reset) always reads all-zero
  assign INT      = (state_q == S_REQ);
  assign BUSY     = (state_q != S_IDLE);
  assign CAS_OE   = in_ack & cas_route;
  assign CAS_OUT  = CAS_OE ? lvl_q : 3'd0;
  assign DATA_OE  = (state_q == S_ACK2) & resp;
  assign DATA_OUT = DATA_OE ? {icw2_q[7:3], lvl_q} : 8'h00;
  assign ISR_SET  = isr_set_q;
  assign EOI_CLR  = eoi_clr_q;

endmodule
`default_nettype wire
